// File: rtl/pac_move_commit_if.sv
// Board RAM port between the Pac-Man move writer and the GameBoard RAM.
// The writer owns the address/write side; the board returns sprite codes
// one cycle after it sees a read address.
interface pac_move_commit_if #(
   parameter int X_W = 5,
   parameter int Y_W = 5
);
   logic [X_W-1:0] rd_x;
   logic [Y_W-1:0] rd_y;
   logic [3:0]     rd_data;
   logic           wr_en;
   logic [X_W-1:0] wr_x;
   logic [Y_W-1:0] wr_y;
   logic [3:0]     wr_data;

   modport master (
      output rd_x, rd_y, wr_en, wr_x, wr_y, wr_data,
      input  rd_data
   );

   modport slave (
      input  rd_x, rd_y, wr_en, wr_x, wr_y, wr_data,
      output rd_data
   );
endinterface

// File: rtl/pac_move_commit.sv
// Pac-Man move writer: on each game step it reads the target tile, decides
// whether the move is legal, rewrites the two affected tiles and reports what
// was eaten. Every output is a register (or decoded from the state register).
module pac_move_commit #(
   parameter int COLS    = 28,
   parameter int ROWS    = 31,
   parameter int X_W     = 5,
   parameter int Y_W     = 5,
   parameter int START_X = 13,
   parameter int START_Y = 23
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 step,
   input  logic [1:0]           dir,
   pac_move_commit_if.master    board,
   output logic [X_W-1:0]       pac_x,
   output logic [Y_W-1:0]       pac_y,
   output logic                 busy,
   output logic                 done,
   output logic                 blocked,
   output logic                 ate_point,
   output logic                 ate_power,
   output logic                 ate_fruit,
   output logic                 ate_ghost
);

   localparam logic [X_W-1:0] X_LAST  = X_W'(COLS - 1);
   localparam logic [Y_W-1:0] Y_LAST  = Y_W'(ROWS - 1);
   localparam logic [X_W-1:0] X_START = X_W'(START_X);
   localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
   localparam logic [X_W-1:0] X_ONE   = X_W'(1);
   localparam logic [Y_W-1:0] Y_ONE   = Y_W'(1);

   localparam logic [3:0] SPR_SPACE  = 4'd0;
   localparam logic [3:0] SPR_POINT  = 4'd1;
   localparam logic [3:0] SPR_POWER  = 4'd2;
   localparam logic [3:0] SPR_FRUIT  = 4'd3;
   localparam logic [3:0] SPR_EGHOST = 4'd4;
   localparam logic [3:0] SPR_PACMAN = 4'd5;
   localparam logic [3:0] SPR_WALL   = 4'd8;

   typedef enum logic [2:0] {IDLE, READ, EVAL, CLEAR, PLACE} state_t;

   state_t         state, state_nx;
   logic [X_W-1:0] tgt_x, tgt_x_nx, step_x;
   logic [Y_W-1:0] tgt_y, tgt_y_nx, step_y;
   logic [3:0]     tile, tile_nx;
   logic [X_W-1:0] pac_x_nx;
   logic [Y_W-1:0] pac_y_nx;
   logic [X_W-1:0] rd_x_q, rd_x_nx, wr_x_q, wr_x_nx;
   logic [Y_W-1:0] rd_y_q, rd_y_nx, wr_y_q, wr_y_nx;
   logic [3:0]     wr_data_q, wr_data_nx;
   logic           wr_en_q, wr_en_nx;
   logic           done_nx, blocked_nx;
   logic           ate_point_nx, ate_power_nx, ate_fruit_nx, ate_ghost_nx;
   logic           illegal;

   assign board.rd_x    = rd_x_q;
   assign board.rd_y    = rd_y_q;
   assign board.wr_en   = wr_en_q;
   assign board.wr_x    = wr_x_q;
   assign board.wr_y    = wr_y_q;
   assign board.wr_data = wr_data_q;
   assign busy          = (state != IDLE);

   // Pacman, gate, ghost and wall tiles stop the move; everything else is walkable.
   assign illegal = (board.rd_data >= SPR_PACMAN) && (board.rd_data <= SPR_WALL);

   // Neighbour tile in the requested direction, wrapping at every board edge (tunnels).
   always_comb begin
      step_x = pac_x;
      step_y = pac_y;
      case (dir)
         2'd0: step_y = (pac_y == '0)     ? Y_LAST : pac_y - Y_ONE;
         2'd1: step_y = (pac_y == Y_LAST) ? '0     : pac_y + Y_ONE;
         2'd2: step_x = (pac_x == '0)     ? X_LAST : pac_x - X_ONE;
         default: step_x = (pac_x == X_LAST) ? '0  : pac_x + X_ONE;
      endcase
   end

   // Next state and next register values; outputs appear one cycle after the decision.
   always_comb begin
      state_nx     = state;
      tgt_x_nx     = tgt_x;
      tgt_y_nx     = tgt_y;
      tile_nx      = tile;
      pac_x_nx     = pac_x;
      pac_y_nx     = pac_y;
      rd_x_nx      = rd_x_q;
      rd_y_nx      = rd_y_q;
      wr_x_nx      = wr_x_q;
      wr_y_nx      = wr_y_q;
      wr_data_nx   = wr_data_q;
      wr_en_nx     = 1'b0;
      done_nx      = 1'b0;
      blocked_nx   = 1'b0;
      ate_point_nx = 1'b0;
      ate_power_nx = 1'b0;
      ate_fruit_nx = 1'b0;
      ate_ghost_nx = 1'b0;
      case (state)
         IDLE: begin
            if (step) begin
               state_nx = READ;
               tgt_x_nx = step_x;
               tgt_y_nx = step_y;
               rd_x_nx  = step_x;
               rd_y_nx  = step_y;
            end
         end
         READ: begin
            state_nx = EVAL;
         end
         EVAL: begin
            if (illegal) begin
               state_nx   = IDLE;
               done_nx    = 1'b1;
               blocked_nx = 1'b1;
            end else begin
               state_nx   = CLEAR;
               tile_nx    = board.rd_data;
               wr_en_nx   = 1'b1;
               wr_x_nx    = pac_x;
               wr_y_nx    = pac_y;
               wr_data_nx = SPR_SPACE;
            end
         end
         CLEAR: begin
            state_nx   = PLACE;
            wr_en_nx   = 1'b1;
            wr_x_nx    = tgt_x;
            wr_y_nx    = tgt_y;
            wr_data_nx = SPR_PACMAN;
         end
         PLACE: begin
            state_nx     = IDLE;
            pac_x_nx     = tgt_x;
            pac_y_nx     = tgt_y;
            done_nx      = 1'b1;
            ate_point_nx = (tile == SPR_POINT);
            ate_power_nx = (tile == SPR_POWER);
            ate_fruit_nx = (tile == SPR_FRUIT);
            ate_ghost_nx = (tile == SPR_EGHOST);
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight move.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state     <= IDLE;
         tgt_x     <= '0;
         tgt_y     <= '0;
         tile      <= '0;
         pac_x     <= X_START;
         pac_y     <= Y_START;
         rd_x_q    <= '0;
         rd_y_q    <= '0;
         wr_x_q    <= '0;
         wr_y_q    <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         done      <= 1'b0;
         blocked   <= 1'b0;
         ate_point <= 1'b0;
         ate_power <= 1'b0;
         ate_fruit <= 1'b0;
         ate_ghost <= 1'b0;
      end else begin
         state     <= state_nx;
         tgt_x     <= tgt_x_nx;
         tgt_y     <= tgt_y_nx;
         tile      <= tile_nx;
         pac_x     <= pac_x_nx;
         pac_y     <= pac_y_nx;
         rd_x_q    <= rd_x_nx;
         rd_y_q    <= rd_y_nx;
         wr_x_q    <= wr_x_nx;
         wr_y_q    <= wr_y_nx;
         wr_data_q <= wr_data_nx;
         wr_en_q   <= wr_en_nx;
         done      <= done_nx;
         blocked   <= blocked_nx;
         ate_point <= ate_point_nx;
         ate_power <= ate_power_nx;
         ate_fruit <= ate_fruit_nx;
         ate_ghost <= ate_ghost_nx;
      end
   end

endmodule

// File: tb/tb_pac_move_commit.sv
// Directed bench for pac_move_commit with a small GameBoard RAM model.
module tb_pac_move_commit;
   localparam int COLS = 28;
   localparam int ROWS = 31;
   localparam int X_W  = 5;
   localparam int Y_W  = 5;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           step;
   logic [1:0]     dir;
   logic [X_W-1:0] pac_x;
   logic [Y_W-1:0] pac_y;
   logic           busy, done, blocked;
   logic           ate_point, ate_power, ate_fruit, ate_ghost;

   int checks = 0;
   int errors = 0;
   int tb_x, tb_y;

   logic [3:0] board_mem [0:31][0:31];

   pac_move_commit_if #(.X_W(X_W), .Y_W(Y_W)) board ();

   pac_move_commit #(
      .COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W), .START_X(13), .START_Y(23)
   ) dut (
      .Clk(clk), .Reset_n(reset_n), .step(step), .dir(dir), .board(board),
      .pac_x(pac_x), .pac_y(pac_y), .busy(busy), .done(done), .blocked(blocked),
      .ate_point(ate_point), .ate_power(ate_power), .ate_fruit(ate_fruit),
      .ate_ghost(ate_ghost)
   );

   always #5 clk = ~clk;

   // Board RAM model: write port plus one-cycle registered read.
   always @(posedge clk) begin
      if (board.wr_en) board_mem[board.wr_y][board.wr_x] <= board.wr_data;
      board.rd_data <= board_mem[board.rd_y][board.rd_x];
   end

   task automatic check_output(input string tag, input string what,
                               input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s.%s: observed %0d expected %0d", tag, what, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a one-cycle step; returns 1ns into the READ cycle (T+1).
   task automatic launch(input logic [1:0] d);
      @(negedge clk);
      step = 1'b1;
      dir  = d;
      @(posedge clk);
      #1;
      step = 1'b0;
   endtask

   task automatic model_target(input logic [1:0] d, output int tx, output int ty);
      tx = tb_x;
      ty = tb_y;
      case (d)
         2'd0: ty = (tb_y == 0) ? ROWS - 1 : tb_y - 1;
         2'd1: ty = (tb_y == ROWS - 1) ? 0 : tb_y + 1;
         2'd2: tx = (tb_x == 0) ? COLS - 1 : tb_x - 1;
         default: tx = (tb_x == COLS - 1) ? 0 : tb_x + 1;
      endcase
   endtask

   // One full step with the given tile code at the target, checked cycle by cycle.
   task automatic apply_stimulus(input logic [1:0] d, input logic [3:0] code, input string tag);
      int tx, ty;
      logic bad;
      model_target(d, tx, ty);
      board_mem[ty][tx] = code;
      bad = (code >= 4'd5) && (code <= 4'd8);
      launch(d);
      check_output(tag, "rd_x", board.rd_x, tx);
      check_output(tag, "rd_y", board.rd_y, ty);
      check_output(tag, "busy_t1", busy, 1);
      check_output(tag, "wr_en_t1", board.wr_en, 0);
      tick();
      check_output(tag, "wr_en_t2", board.wr_en, 0);
      tick();
      if (bad) begin
         check_output(tag, "done_blk", done, 1);
         check_output(tag, "blocked", blocked, 1);
         check_output(tag, "wr_en_blk", board.wr_en, 0);
         check_output(tag, "ate_any_blk", {ate_point, ate_power, ate_fruit, ate_ghost}, 0);
         check_output(tag, "pac_x_blk", pac_x, tb_x);
         check_output(tag, "pac_y_blk", pac_y, tb_y);
      end else begin
         check_output(tag, "clr_en", board.wr_en, 1);
         check_output(tag, "clr_x", board.wr_x, tb_x);
         check_output(tag, "clr_y", board.wr_y, tb_y);
         check_output(tag, "clr_data", board.wr_data, 0);
         check_output(tag, "done_t3", done, 0);
         tick();
         check_output(tag, "plc_en", board.wr_en, 1);
         check_output(tag, "plc_x", board.wr_x, tx);
         check_output(tag, "plc_y", board.wr_y, ty);
         check_output(tag, "plc_data", board.wr_data, 5);
         tick();
         check_output(tag, "done_mv", done, 1);
         check_output(tag, "blocked_mv", blocked, 0);
         check_output(tag, "wr_en_t5", board.wr_en, 0);
         check_output(tag, "pac_x_mv", pac_x, tx);
         check_output(tag, "pac_y_mv", pac_y, ty);
         check_output(tag, "ate_point", ate_point, code == 4'd1);
         check_output(tag, "ate_power", ate_power, code == 4'd2);
         check_output(tag, "ate_fruit", ate_fruit, code == 4'd3);
         check_output(tag, "ate_ghost", ate_ghost, code == 4'd4);
         check_output(tag, "mem_old", board_mem[tb_y][tb_x], 0);
         check_output(tag, "mem_new", board_mem[ty][tx], 5);
         tb_x = tx;
         tb_y = ty;
      end
      tick();
      check_output(tag, "done_after", done, 0);
      check_output(tag, "busy_after", busy, 0);
   endtask

   // Directed sequence: reset, moves, blocks, code sweep, tunnel, busy/step, reset mid-move.
   initial begin
      int tx, ty, wr_cnt, done_cnt, fruit_cnt;
      reset_n = 1'b0;
      step    = 1'b0;
      dir     = 2'd0;
      for (int yy = 0; yy < 32; yy++)
         for (int xx = 0; xx < 32; xx++)
            board_mem[yy][xx] = 4'd0;
      tick(); tick(); tick();
      check_output("reset", "pac_x", pac_x, 13);
      check_output("reset", "pac_y", pac_y, 23);
      check_output("reset", "busy", busy, 0);
      check_output("reset", "done", done, 0);
      check_output("reset", "blocked", blocked, 0);
      check_output("reset", "wr_en", board.wr_en, 0);
      check_output("reset", "rd_x", board.rd_x, 0);
      check_output("reset", "wr_x", board.wr_x, 0);
      check_output("reset", "wr_data", board.wr_data, 0);
      check_output("reset", "ate_any", {ate_point, ate_power, ate_fruit, ate_ghost}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      tb_x = 13;
      tb_y = 23;

      $display("[TB] move right onto point");
      apply_stimulus(2'd3, 4'd1, "right_point");
      check_output("right_point", "pac_x_abs", pac_x, 14);

      $display("[TB] blocked by wall");
      apply_stimulus(2'd0, 4'd8, "up_wall");

      $display("[TB] sprite code sweep");
      for (int c = 0; c < 16; c++)
         apply_stimulus(2'd3, 4'(c), $sformatf("code_%0d", c));
      check_output("sweep", "pac_x_abs", pac_x, 26);

      $display("[TB] wrap right, climb, tunnel left");
      apply_stimulus(2'd3, 4'd0, "to_edge");
      apply_stimulus(2'd3, 4'd0, "wrap_right");
      check_output("wrap_right", "pac_x_abs", pac_x, 0);
      for (int k = 0; k < 9; k++)
         apply_stimulus(2'd0, 4'd1, "climb");
      check_output("climb", "pac_y_abs", pac_y, 14);
      apply_stimulus(2'd2, 4'd0, "tunnel_left");
      check_output("tunnel_left", "pac_x_abs", pac_x, 27);
      check_output("tunnel_left", "pac_y_abs", pac_y, 14);

      $display("[TB] extra step pulses while busy");
      model_target(2'd2, tx, ty);
      board_mem[ty][tx] = 4'd3;
      launch(2'd2);
      step = 1'b1;
      wr_cnt = 0;
      done_cnt = 0;
      fruit_cnt = 0;
      for (int c = 1; c <= 8; c++) begin
         if (board.wr_en) wr_cnt++;
         if (done) done_cnt++;
         if (ate_fruit) fruit_cnt++;
         if (c == 5) step = 1'b0;
         tick();
      end
      check_output("extra_step", "wr_cnt", wr_cnt, 2);
      check_output("extra_step", "done_cnt", done_cnt, 1);
      check_output("extra_step", "fruit_cnt", fruit_cnt, 1);
      check_output("extra_step", "busy", busy, 0);
      check_output("extra_step", "pac_x", pac_x, 26);
      tb_x = 26;

      $display("[TB] step on the done cycle");
      board_mem[14][25] = 4'd0;
      board_mem[14][24] = 4'd0;
      launch(2'd2);
      tick(); tick(); tick(); tick();
      check_output("step_on_done", "done", done, 1);
      check_output("step_on_done", "pac_x1", pac_x, 25);
      step = 1'b1;
      dir  = 2'd2;
      tick();
      step = 1'b0;
      check_output("step_on_done", "busy", busy, 1);
      check_output("step_on_done", "rd_x", board.rd_x, 24);
      tick(); tick(); tick(); tick();
      check_output("step_on_done", "done2", done, 1);
      check_output("step_on_done", "pac_x2", pac_x, 24);
      tb_x = 24;
      tick();

      $display("[TB] reset during CLEAR");
      board_mem[14][25] = 4'd1;
      launch(2'd3);
      tick(); tick();
      check_output("reset_mid", "wr_en_clear", board.wr_en, 1);
      reset_n = 1'b0;
      tick();
      check_output("reset_mid", "wr_en", board.wr_en, 0);
      check_output("reset_mid", "pac_x", pac_x, 13);
      check_output("reset_mid", "pac_y", pac_y, 23);
      check_output("reset_mid", "busy", busy, 0);
      reset_n = 1'b1;
      wr_cnt = 0;
      done_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         if (board.wr_en) wr_cnt++;
         if (done) done_cnt++;
         tick();
      end
      check_output("reset_mid", "wr_cnt", wr_cnt, 0);
      check_output("reset_mid", "done_cnt", done_cnt, 0);
      tb_x = 13;
      tb_y = 23;

      $display("[TB] move down onto powerball after reset");
      apply_stimulus(2'd1, 4'd2, "down_power");
      check_output("down_power", "pac_y_abs", pac_y, 24);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
